// File: rtl/ws2812_unipolar_rz_decoder.sv
// Purpose: decode a unipolar RZ (WS2812-style) line into MSB-first bytes, flag latch intervals and timing faults.
// Latency: a pin transition reaches the registered outputs 3 clk edges after it is first sampled.
// Backpressure: none; the line cannot be stalled, so every output is a free-running one-cycle pulse.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   din            asynchronous serial line (2-flop synchronised internally)
//   data_byte      last completed byte, held until the next one completes
//   byte_valid     one-cycle pulse when data_byte updates
//   reset_detected one-cycle pulse when a long-low latch interval is recognised
//   frame_error    one-cycle pulse on a timing violation or a discarded partial byte
//   synced         high while locked to the bit stream (not hunting for a latch interval)
module ws2812_unipolar_rz_decoder #(
    parameter int CLK_FREQ_KHZ   = 10000,
    parameter int T_HI_MIN_NS    = 100,
    parameter int T_HI_THRESH_NS = 500,
    parameter int T_HI_MAX_NS    = 1000,
    parameter int T_RESET_NS     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       reset_detected,
    output logic       frame_error,
    output logic       synced
);

    localparam int CLK_PERIOD_NS = 1000000 / CLK_FREQ_KHZ;
    localparam int MIN_TICKS     = T_HI_MIN_NS / CLK_PERIOD_NS;
    localparam int THRESH_TICKS  = T_HI_THRESH_NS / CLK_PERIOD_NS;
    localparam int MAX_TICKS     = T_HI_MAX_NS / CLK_PERIOD_NS;
    localparam int RESET_TICKS   = T_RESET_NS / CLK_PERIOD_NS;
    localparam int CW            = $clog2(RESET_TICKS + 1);

    localparam logic [CW-1:0] MIN_C    = CW'(MIN_TICKS);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH_TICKS);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_TICKS);
    localparam logic [CW-1:0] RESET_C  = CW'(RESET_TICKS);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LOW,
        ST_HIGH
    } state_t;

    logic          sync_q1;
    logic          din_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_byte_n;
    logic          byte_valid_n, reset_detected_n, frame_error_n;

    // Two-flop synchroniser for the asynchronous line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            din_s   <= 1'b0;
        end else begin
            sync_q1 <= din;
            din_s   <= sync_q1;
        end
    end

    // cnt never reaches RESET_C+1 here: SYNC leaves at RESET_C, LOW saturates,
    // and HIGH aborts long before RESET_C.
    assign cnt_inc = cnt + ONE_C;

    always_comb begin
        state_n          = state;
        cnt_n            = cnt;
        bit_cnt_n        = bit_cnt;
        shreg_n          = shreg;
        data_byte_n      = data_byte;
        byte_valid_n     = 1'b0;
        reset_detected_n = 1'b0;
        frame_error_n    = 1'b0;

        case (state)
            ST_SYNC: begin
                if (din_s) begin
                    cnt_n = '0;
                end else if (cnt_inc == RESET_C) begin
                    reset_detected_n = 1'b1;
                    state_n          = ST_LOW;
                    cnt_n            = RESET_C;
                    bit_cnt_n        = 3'd0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end

            ST_LOW: begin
                if (din_s) begin
                    state_n = ST_HIGH;
                    cnt_n   = ONE_C;
                end else if (cnt != RESET_C) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == RESET_C) begin
                        reset_detected_n = 1'b1;
                        // A latch arriving mid-byte discards the partial byte.
                        if (bit_cnt != 3'd0) begin
                            frame_error_n = 1'b1;
                            bit_cnt_n     = 3'd0;
                        end
                    end
                end
            end

            ST_HIGH: begin
                if (din_s) begin
                    if (cnt >= MAX_C) begin
                        // Stuck high: drop lock and wait for a fresh latch.
                        frame_error_n = 1'b1;
                        bit_cnt_n     = 3'd0;
                        state_n       = ST_SYNC;
                        cnt_n         = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else if (cnt < MIN_C) begin
                    // Glitch; this cycle is already the first low sample.
                    frame_error_n = 1'b1;
                    bit_cnt_n     = 3'd0;
                    state_n       = ST_SYNC;
                    cnt_n         = ONE_C;
                end else begin
                    shreg_n   = {shreg[6:0], (cnt >= THRESH_C)};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        data_byte_n  = shreg_n;
                        byte_valid_n = 1'b1;
                    end
                    state_n = ST_LOW;
                    cnt_n   = ONE_C;
                end
            end

            default: begin
                state_n = ST_SYNC;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_SYNC;
            cnt            <= '0;
            bit_cnt        <= 3'd0;
            shreg          <= 8'd0;
            data_byte      <= 8'd0;
            byte_valid     <= 1'b0;
            reset_detected <= 1'b0;
            frame_error    <= 1'b0;
            synced         <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            bit_cnt        <= bit_cnt_n;
            shreg          <= shreg_n;
            data_byte      <= data_byte_n;
            byte_valid     <= byte_valid_n;
            reset_detected <= reset_detected_n;
            frame_error    <= frame_error_n;
            synced         <= (state_n != ST_SYNC);
        end
    end

endmodule

// File: doc/ws2812_unipolar_rz_decoder.md
Name: ws2812_unipolar_rz_decoder

Overview:
- Receive-side counterpart of our WS2812 RZ encoder: samples a single-wire unipolar return-to-zero line, classifies each high pulse as a 0 or 1 by width, and assembles MSB-first bytes.
- Detects the long-low reset/latch interval and flags malformed timing.
- Used for loopback verification of the LED driver and for daisy-chain sniffing/forwarding on the same clock domain.

Parameters:
- CLK_FREQ_KHZ, 10000, system clock frequency in kHz; CLK_PERIOD_NS = 1000000 / CLK_FREQ_KHZ (integer division).
- T_HI_MIN_NS, 100, shortest high pulse accepted; shorter pulses are glitch errors.
- T_HI_THRESH_NS, 500, high width at or above this value decodes as 1, below decodes as 0.
- T_HI_MAX_NS, 1000, longest legal high pulse; exceeding it is a stuck-high error.
- T_RESET_NS, 50000, continuous low time recognised as reset/latch.
- Tick values are each parameter divided by CLK_PERIOD_NS (integer division). Defaults give MIN=1, THRESH=5, MAX=10, RESET=500.
- Legal parameter sets satisfy 1 <= MIN <= THRESH <= MAX < RESET.
- Counter width is $clog2(RESET_TICKS+1).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  asynchronous WS2812 data line.
- data_byte  out  8  last completed byte, MSB received first; holds its value until the next byte completes.
- byte_valid  out  1  one-cycle pulse when data_byte is updated.
- reset_detected  out  1  one-cycle pulse when a reset interval is recognised.
- frame_error  out  1  one-cycle pulse on any timing violation or partial-byte discard.
- synced  out  1  high while the decoder is in LOW or HIGH (i.e. not in SYNC).

Behaviour:
- Input synchronisation: din passes through a 2-flop synchroniser to give din_s. All measurements use din_s.
- Outputs are registered. Every pin transition reaches the outputs 3 clk edges after it is first sampled.
- Reset (rst=1 at a clk edge):
  - state=SYNC, counter=0, bit_count=0, shift register=0, synchroniser flops=0.
  - data_byte=0; byte_valid, reset_detected, frame_error, synced all 0.
  - rst has priority over every other event.
- Internal state: 3-state FSM {SYNC, LOW, HIGH}, a saturating counter, a 3-bit bit_count, and an 8-bit shift register.
- SYNC:
  - din_s=1 clears the counter.
  - din_s=0 increments the counter.
  - When the counter reaches RESET_TICKS: pulse reset_detected, go to LOW with counter held at RESET_TICKS, bit_count=0.
- LOW:
  - din_s=0: counter increments, saturating at RESET_TICKS.
  - On the increment that makes counter == RESET_TICKS: pulse reset_detected.
  - If bit_count != 0 at that moment, also pulse frame_error (same cycle) and clear bit_count; the partial byte is discarded and data_byte is unchanged.
  - No repeat pulse while saturated.
  - din_s=1: go to HIGH, counter=1.
  - Low gaps shorter than RESET_TICKS between bits are legal and carry no error.
- HIGH:
  - din_s=1: counter increments. If counter would exceed MAX_TICKS: pulse frame_error, clear bit_count, go to SYNC with counter=0.
  - din_s=0 (falling edge): width = counter.
    - If width < MIN_TICKS: pulse frame_error, clear bit_count, go to SYNC with counter=1.
    - Otherwise bit = (width >= THRESH_TICKS), shifted in at the LSB with a left shift, bit_count increments.
    - If bit_count was 7: load data_byte with the completed shift value, pulse byte_valid, bit_count wraps to 0.
    - Then go to LOW with counter=1.
- Simultaneous events: a byte completing and a later error are separate cycles; byte_valid and frame_error are never both high from the same pulse.
- Period length (high + low) is not checked beyond the reset threshold.

Test Plan:
- rst for 2 cycles, din=0 for 500 clk -> synced=1 and one reset_detected pulse about 503 cycles after rst release; no frame_error.
- After sync, send byte 0xA5 as 1 = 7 ticks high / 4 low and 0 = 3 high / 8 low -> one byte_valid pulse with data_byte=0xA5, 3 clk after the 8th falling edge.
- Send 0xFF then 0x00 back to back, then 500 low ticks -> byte_valid pulses with 0xFF and then 0x00, followed by reset_detected with no frame_error.
- Send 3 valid bits, then 500 low ticks -> reset_detected and frame_error in the same cycle, data_byte unchanged, next full byte decodes correctly.
- Hold din high for 11 ticks -> frame_error and synced=0; a following 1-tick-high pulse does not decode; after 500 low ticks, synced=1 again.
- Assert rst in the middle of a byte -> all outputs 0 the next cycle, synced=0, and decoding resumes only after a fresh 500-tick low interval.
